// File: rtl/rfx8_lock_supervisor.sv
// rfx8_lock_supervisor
//   Brings the RFx8 PLL out of reset, waits for lock, qualifies it for a
//   number of stable cycles, then releases the 184.48 MHz domain reset.
//   Loses lock in RUN -> back to WAIT_LOCK; lock timeout -> PLL reset retry.
//
// Parameters
//   SYNC_STAGES    locked_in synchronizer depth (2..4)
//   PLL_RST_CYCLES refclk cycles of pll_rst_out per PLL reset pulse
//   LOCK_TIMEOUT   refclk cycles allowed in WAIT_LOCK before retry
//   STABLE_CYCLES  consecutive locked cycles required before RUN
//
// Ports
//   refclk        in   PLL reference clock, all logic on rising edge
//   rst           in   synchronous active-high reset
//   locked_in     in   PLL lock, asynchronous to refclk
//   pll_rst_out   out  registered PLL reset request
//   rst_out       out  registered active-high downstream reset
//   ready         out  registered, high only in RUN
//   retry_cnt     out  [3:0] timeout retries, saturating
//   lock_loss_cnt out  [7:0] lock losses in RUN, saturating
//   state_o       out  [1:0] 0 RESET_PLL, 1 WAIT_LOCK, 2 STABLE, 3 RUN
//
// Build option
//   RFX8_LOCK_LOSS_CNT_EN  defined: lock_loss_cnt register implemented;
//                          undefined: lock_loss_cnt tied to 0.
module rfx8_lock_supervisor #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 4096,
  parameter int unsigned STABLE_CYCLES  = 1024
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked_in,
  output logic       pll_rst_out,
  output logic       rst_out,
  output logic       ready,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_loss_cnt,
  output logic [1:0] state_o
);

  localparam int unsigned PW = $clog2(PLL_RST_CYCLES) + 1;
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam int unsigned SW = $clog2(STABLE_CYCLES) + 1;

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  // ---------------------------------------------------------------
  // locked_in synchronizer
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_locked_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], locked_in};
    end
  end

  assign w_locked_s = r_sync[SYNC_STAGES-1];

  // ---------------------------------------------------------------
  // FSM state and phase counters
  // ---------------------------------------------------------------
  state_t          r_state;
  state_t          w_next;
  logic [PW-1:0]   r_pcnt;
  logic [PW-1:0]   w_pcnt_nxt;
  logic [TW-1:0]   r_tcnt;
  logic [TW-1:0]   w_tcnt_nxt;
  logic [SW-1:0]   r_scnt;
  logic [SW-1:0]   w_scnt_nxt;
  logic            w_retry_inc;
  logic            r_pll_rst;
  logic            r_rst_out;
  logic            r_ready;
  logic [3:0]      r_retry_cnt;

  // Counter next values default to zero, so every state transition
  // clears all phase counters; only the counter owned by the current
  // state advances while the state is held.
  always_comb begin
    w_next      = r_state;
    w_pcnt_nxt  = '0;
    w_tcnt_nxt  = '0;
    w_scnt_nxt  = '0;
    w_retry_inc = 1'b0;
    case (r_state)
      RESET_PLL: begin
        if (r_pcnt == PW'(PLL_RST_CYCLES - 1)) begin
          w_next = WAIT_LOCK;
        end else begin
          w_pcnt_nxt = r_pcnt + PW'(1);
        end
      end
      WAIT_LOCK: begin
        if (w_locked_s) begin
          w_next = STABLE;
        end else if (r_tcnt == TW'(LOCK_TIMEOUT - 1)) begin
          w_next      = RESET_PLL;
          w_retry_inc = 1'b1;
        end else begin
          w_tcnt_nxt = r_tcnt + TW'(1);
        end
      end
      STABLE: begin
        // A drop in the final qualifying cycle still wins over RUN.
        if (!w_locked_s) begin
          w_next = WAIT_LOCK;
        end else if (r_scnt == SW'(STABLE_CYCLES - 1)) begin
          w_next = RUN;
        end else begin
          w_scnt_nxt = r_scnt + SW'(1);
        end
      end
      RUN: begin
        if (!w_locked_s) begin
          w_next = WAIT_LOCK;
        end
      end
      default: begin
        w_next = RESET_PLL;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the
  // same edge as state_o, without decode glitches.
  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state     <= RESET_PLL;
      r_pcnt      <= '0;
      r_tcnt      <= '0;
      r_scnt      <= '0;
      r_pll_rst   <= 1'b1;
      r_rst_out   <= 1'b1;
      r_ready     <= 1'b0;
      r_retry_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_pcnt    <= w_pcnt_nxt;
      r_tcnt    <= w_tcnt_nxt;
      r_scnt    <= w_scnt_nxt;
      r_pll_rst <= (w_next == RESET_PLL);
      r_rst_out <= (w_next != RUN);
      r_ready   <= (w_next == RUN);
      if (w_retry_inc && (r_retry_cnt != '1)) begin
        r_retry_cnt <= r_retry_cnt + 4'd1;
      end
    end
  end

  assign pll_rst_out = r_pll_rst;
  assign rst_out     = r_rst_out;
  assign ready       = r_ready;
  assign retry_cnt   = r_retry_cnt;
  assign state_o     = r_state;

  // ---------------------------------------------------------------
  // Lock-loss counter (optional)
  // ---------------------------------------------------------------
`ifdef RFX8_LOCK_LOSS_CNT_EN
  logic       w_loss_inc;
  logic [7:0] r_loss_cnt;

  assign w_loss_inc = (r_state == RUN) && !w_locked_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_loss_cnt <= '0;
    end else if (w_loss_inc && (r_loss_cnt != '1)) begin
      r_loss_cnt <= r_loss_cnt + 8'd1;
    end
  end

  assign lock_loss_cnt = r_loss_cnt;
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_rfx8_lock_supervisor.sv
// Self-checking bench for rfx8_lock_supervisor.
module tb_rfx8_lock_supervisor;

  localparam int SS  = 2;
  localparam int PRC = 4;
  localparam int LT  = 32;
  localparam int SC  = 8;
`ifdef RFX8_LOCK_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       locked_in = 1'b0;
  logic       pll_rst_out;
  logic       rst_out;
  logic       ready;
  logic [3:0] retry_cnt;
  logic [7:0] lock_loss_cnt;
  logic [1:0] state_o;

  int total = 0;
  int bad = 0;

  rfx8_lock_supervisor #(
    .SYNC_STAGES(SS),
    .PLL_RST_CYCLES(PRC),
    .LOCK_TIMEOUT(LT),
    .STABLE_CYCLES(SC)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .locked_in(locked_in),
    .pll_rst_out(pll_rst_out),
    .rst_out(rst_out),
    .ready(ready),
    .retry_cnt(retry_cnt),
    .lock_loss_cnt(lock_loss_cnt),
    .state_o(state_o)
  );

  always #5 refclk = ~refclk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural reference: phase number plus cycles spent in it; the
  // synchronizer is a plain delay line of locked_in samples.
  int m_st = 0;
  int m_t = 0;
  int m_retry = 0;
  int m_loss = 0;
  bit m_ls;
  bit mq[$];

  always @(posedge refclk) begin
    if (rst) begin
      m_st = 0; m_t = 0; m_retry = 0; m_loss = 0;
      mq.delete();
      for (int i = 0; i < SS; i++) mq.push_back(1'b0);
    end else begin
      m_ls = mq.pop_front();
      mq.push_back(locked_in);
      case (m_st)
        0: begin
          m_t++;
          if (m_t == PRC) begin m_st = 1; m_t = 0; end
        end
        1: begin
          if (m_ls) begin m_st = 2; m_t = 0; end
          else begin
            m_t++;
            if (m_t == LT) begin
              m_st = 0; m_t = 0;
              if (m_retry < 15) m_retry++;
            end
          end
        end
        2: begin
          if (!m_ls) begin m_st = 1; m_t = 0; end
          else begin
            m_t++;
            if (m_t == SC) begin m_st = 3; m_t = 0; end
          end
        end
        default: begin
          if (!m_ls) begin
            m_st = 1; m_t = 0;
            if (m_loss < 255) m_loss++;
          end
        end
      endcase
    end
  end

  task automatic do_reset(input int n);
    @(negedge refclk);
    rst = 1'b1;
    repeat (n) @(negedge refclk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    locked_in = 1'b0;
    @(negedge refclk);
    rst = 1'b1;
    repeat (3) @(negedge refclk);
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", state_o); end
    total++; if (pll_rst_out !== 1'b1) begin bad++; $display("FAIL rst_pll got=%b exp=1", pll_rst_out); end
    total++; if (rst_out !== 1'b1) begin bad++; $display("FAIL rst_rst_out got=%b exp=1", rst_out); end
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", ready); end
    total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL rst_retry got=%0d exp=0", retry_cnt); end
    total++; if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL rst_loss got=%0d exp=0", lock_loss_cnt); end
  endtask

  // Constant lock: 4 PLL reset cycles, WAIT one cycle, 8 STABLE, RUN at edge 13.
  task automatic test_lock_const;
    int pll_hi;
    locked_in = 1'b1;
    do_reset(3);
    pll_hi = (pll_rst_out === 1'b1) ? 1 : 0;
    for (int m = 1; m <= 20; m++) begin
      @(negedge refclk);
      if (pll_rst_out === 1'b1) pll_hi++;
      if (m == 4) begin
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL const_wait got=%0d exp=1", state_o); end
      end
      if (m == 5) begin
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL const_stable got=%0d exp=2", state_o); end
      end
      if (m == 12) begin
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL const_early_ready got=%b exp=0", ready); end
      end
      if (m == 13 || m == 16) begin
        total++; if (ready !== 1'b1 || rst_out !== 1'b0) begin bad++; $display("FAIL const_run m=%0d ready=%b rst_out=%b exp ready=1 rst_out=0", m, ready, rst_out); end
      end
    end
    total++; if (pll_hi != PRC) begin bad++; $display("FAIL const_pll_len got=%0d exp=%0d", pll_hi, PRC); end
    total++; if (retry_cnt !== 4'd0) begin bad++; $display("FAIL const_retry got=%0d exp=0", retry_cnt); end
  endtask

  // No lock: period PRC+LT, retry count saturates at 15.
  task automatic test_timeout;
    int per;
    int expr;
    per = PRC + LT;
    locked_in = 1'b0;
    do_reset(3);
    for (int m = 1; m <= per * 18; m++) begin
      @(negedge refclk);
      total++;
      if (pll_rst_out !== ((m % per) < PRC)) begin
        bad++; $display("FAIL timeout_pll m=%0d got=%b exp=%b", m, pll_rst_out, ((m % per) < PRC));
      end
      if (m % per == 0) begin
        expr = (m / per > 15) ? 15 : m / per;
        total++;
        if (retry_cnt !== 4'(expr)) begin bad++; $display("FAIL timeout_retry m=%0d got=%0d exp=%0d", m, retry_cnt, expr); end
      end
    end
  endtask

  // Drop seen only in the final STABLE cycle must send the FSM to WAIT_LOCK.
  task automatic test_stable_glitch;
    locked_in = 1'b1;
    do_reset(3);
    for (int m = 1; m <= 24; m++) begin
      @(negedge refclk);
      if (m == 10) locked_in = 1'b0;
      if (m == 11) locked_in = 1'b1;
      total++;
      if (ready !== (m >= 22) || rst_out !== (m < 22)) begin
        bad++; $display("FAIL glitch_out m=%0d ready=%b rst_out=%b exp_ready=%b", m, ready, rst_out, (m >= 22));
      end
      if (m == 13) begin
        total++; if (state_o !== 2'd1) begin bad++; $display("FAIL glitch_wait got=%0d exp=1", state_o); end
      end
      if (m == 14) begin
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL glitch_restable got=%0d exp=2", state_o); end
      end
    end
  endtask

  // Lock lost 5 cycles in RUN; reaction SS+1 edges after the drop.
  task automatic test_run_loss;
    bit expr;
    locked_in = 1'b1;
    do_reset(3);
    for (int m = 1; m <= 34; m++) begin
      @(negedge refclk);
      if (m == 16) locked_in = 1'b0;
      if (m == 21) locked_in = 1'b1;
      expr = (m >= 13 && m < 19) || (m >= 32);
      total++;
      if (ready !== expr || rst_out !== !expr) begin
        bad++; $display("FAIL loss_out m=%0d ready=%b rst_out=%b exp_ready=%b", m, ready, rst_out, expr);
      end
      if (m == 19 || m == 34) begin
        total++;
        if (lock_loss_cnt !== (LOSS_EN ? 8'd1 : 8'd0)) begin bad++; $display("FAIL loss_cnt m=%0d got=%0d exp=%0d", m, lock_loss_cnt, LOSS_EN ? 1 : 0); end
      end
      if (m == 24) begin
        total++; if (state_o !== 2'd2) begin bad++; $display("FAIL loss_restable got=%0d exp=2", state_o); end
      end
    end
  endtask

  // Reset asserted in STABLE and then in RUN.
  task automatic test_rst_mid;
    locked_in = 1'b1;
    do_reset(3);
    repeat (7) @(negedge refclk);
    total++; if (state_o !== 2'd2) begin bad++; $display("FAIL mid_pre_stable got=%0d exp=2", state_o); end
    rst = 1'b1;
    @(negedge refclk);
    total++;
    if (state_o !== 2'd0 || pll_rst_out !== 1'b1 || rst_out !== 1'b1 || ready !== 1'b0 || retry_cnt !== 4'd0 || lock_loss_cnt !== 8'd0) begin
      bad++; $display("FAIL mid_stable_rst st=%0d pll=%b rst_out=%b ready=%b exp st=0 pll=1 rst_out=1 ready=0", state_o, pll_rst_out, rst_out, ready);
    end
    rst = 1'b0;
    repeat (14) @(negedge refclk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_pre_run got=%b exp=1", ready); end
    rst = 1'b1;
    @(negedge refclk);
    total++;
    if (state_o !== 2'd0 || pll_rst_out !== 1'b1 || rst_out !== 1'b1 || ready !== 1'b0) begin
      bad++; $display("FAIL mid_run_rst st=%0d pll=%b rst_out=%b ready=%b exp st=0 pll=1 rst_out=1 ready=0", state_o, pll_rst_out, rst_out, ready);
    end
    rst = 1'b0;
  endtask

  // 300 back-to-back lock losses, then reset while in RUN.
  task automatic test_back_to_back;
    int k;
    int n;
    locked_in = 1'b1;
    do_reset(3);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      k = 0;
      while (ready !== 1'b1 && k < 40) begin @(negedge refclk); k++; end
      total++;
      if (ready !== 1'b1) begin bad++; $display("FAIL b2b_wait_run i=%0d got=%b exp=1", i, ready); break; end
      locked_in = 1'b0;
      @(negedge refclk);
      locked_in = 1'b1;
      k = 0;
      while (ready !== 1'b0 && k < 10) begin @(negedge refclk); k++; end
      total++;
      if (ready !== 1'b0) begin bad++; $display("FAIL b2b_wait_loss i=%0d got=%b exp=0", i, ready); break; end
      n++;
      if (n == 100) begin
        total++;
        if (lock_loss_cnt !== (LOSS_EN ? 8'd100 : 8'd0)) begin bad++; $display("FAIL b2b_cnt100 got=%0d exp=%0d", lock_loss_cnt, LOSS_EN ? 100 : 0); end
      end
    end
    k = 0;
    while (ready !== 1'b1 && k < 40) begin @(negedge refclk); k++; end
    total++;
    if (lock_loss_cnt !== (LOSS_EN ? 8'd255 : 8'd0)) begin bad++; $display("FAIL b2b_cnt_sat got=%0d exp=%0d", lock_loss_cnt, LOSS_EN ? 255 : 0); end
    rst = 1'b1;
    @(negedge refclk);
    total++;
    if (lock_loss_cnt !== 8'd0 || ready !== 1'b0 || state_o !== 2'd0) begin
      bad++; $display("FAIL b2b_rst_clear loss=%0d ready=%b st=%0d exp 0/0/0", lock_loss_cnt, ready, state_o);
    end
    rst = 1'b0;
  endtask

  // Random lock segments and occasional resets against the model.
  task automatic test_random;
    int seg;
    bit cur;
    seg = 0;
    cur = 1'b1;
    do_reset(2);
    for (int c = 0; c < 3000; c++) begin
      @(negedge refclk);
      total++;
      if (state_o !== 2'(m_st) || pll_rst_out !== (m_st == 0) || rst_out !== (m_st != 3) || ready !== (m_st == 3)) begin
        bad++; $display("FAIL rand_state c=%0d st=%0d pll=%b rst_out=%b ready=%b exp_st=%0d", c, state_o, pll_rst_out, rst_out, ready, m_st);
      end
      total++;
      if (retry_cnt !== 4'(m_retry)) begin bad++; $display("FAIL rand_retry c=%0d got=%0d exp=%0d", c, retry_cnt, m_retry); end
      total++;
      if (lock_loss_cnt !== (LOSS_EN ? 8'(m_loss) : 8'd0)) begin bad++; $display("FAIL rand_loss c=%0d got=%0d exp=%0d", c, lock_loss_cnt, LOSS_EN ? m_loss : 0); end
      if (seg == 0) begin
        seg = $urandom_range(1, 60);
        cur = ($urandom_range(0, 9) < 7);
      end
      seg--;
      locked_in = cur;
      rst = ($urandom_range(0, 799) == 0);
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lock_const();
    test_timeout();
    test_stable_glitch();
    test_run_loss();
    test_rst_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
